// File: rtl/avfs_pkg.sv
// Shared constants for the AVFS controller: register map, field positions,
// reset defaults and the frequency clamp helper.
package avfs_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_WINDOW = 8'h04;
  localparam logic [7:0] ADDR_THRESH = 8'h08;
  localparam logic [7:0] ADDR_LIMITS = 8'h0C;
  localparam logic [7:0] ADDR_STATUS = 8'h10;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MAN_BIT  = 1;
  localparam int CTRL_MANF_LSB = 4;
  localparam int THRESH_HI_LSB = 16;
  localparam int LIMITS_MAX_LSB = 8;

  localparam logic [15:0] WINDOW_RST = 16'd16;
  localparam logic [15:0] LO_RST     = 16'd4;
  localparam logic [15:0] HI_RST     = 16'd12;
  localparam logic [3:0]  MIN_RST    = 4'd0;
  localparam logic [3:0]  MAX_RST    = 4'd15;
  localparam logic [3:0]  FREQ_RST   = 4'd8;

  function automatic logic [3:0] clamp(input logic [3:0] f, input logic [3:0] lo,
                                       input logic [3:0] hi);
    if (f < lo)      clamp = lo;
    else if (f > hi) clamp = hi;
    else             clamp = f;
  endfunction

endpackage

// File: rtl/avfs_activity_monitor.sv
// Window and activity counters; pulses done on the last window cycle with the
// window's total (including the current cycle's activity).
module avfs_activity_monitor
  import avfs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        restart,
  input  logic        activity,
  input  logic [15:0] window,
  output logic        done,
  output logic [15:0] total
);

  logic [15:0] win_cnt, act_cnt;
  logic        last;

  // >= rather than == so a window shrink can never strand the counter
  assign last  = (win_cnt >= window - 16'd1);
  assign total = act_cnt + {15'd0, activity};
  assign done  = en && !restart && last;

  always_ff @(posedge clk) begin
    if (!rst_n || !en || restart || last) begin
      win_cnt <= '0;
      act_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 16'd1;
      act_cnt <= total;
    end
  end

endmodule

// File: rtl/avfs_controller.sv
// AVFS controller top: register file, per-window freq step, clamp and read mux.
// Optional AVFS_MANUAL_EN adds the CTRL MAN/MAN_FREQ manual override.
module avfs_controller
  import avfs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        activity,
  output logic [3:0]  freq_sel,
  input  logic        apb_sel,
  input  logic        apb_we,
  input  logic [7:0]  apb_addr,
  input  logic [31:0] apb_wdata,
  output logic [31:0] apb_rdata
);

  logic        en, man;
  logic [3:0]  man_freq, min_f, max_f, freq, freq_next, step;
  logic [15:0] window, lo, hi, status_cnt, win_total;
  logic        wr, restart, win_done;

  assign wr       = apb_sel && apb_we;
  assign restart  = wr && (apb_addr == ADDR_WINDOW || apb_addr == ADDR_THRESH);
  assign freq_sel = freq;

  avfs_activity_monitor u_mon (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en && !man),
    .restart  (restart),
    .activity (activity),
    .window   (window),
    .done     (win_done),
    .total    (win_total)
  );

`ifdef AVFS_MANUAL_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      man      <= 1'b0;
      man_freq <= 4'd0;
    end else if (wr && apb_addr == ADDR_CTRL) begin
      man      <= apb_wdata[CTRL_MAN_BIT];
      man_freq <= apb_wdata[CTRL_MANF_LSB +: 4];
    end
  end
`else
  assign man      = 1'b0;
  assign man_freq = 4'd0;
`endif

  // Step, then clamp against the limits in force before this edge, so a
  // LIMITS write pulls freq in one cycle later.
  always_comb begin
    step = freq;
    if (en && man) step = man_freq;
    else if (win_done) begin
      if (win_total >= hi && freq < max_f)     step = freq + 4'd1;
      else if (win_total <= lo && freq > min_f) step = freq - 4'd1;
    end
    freq_next = clamp(step, min_f, max_f);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en         <= 1'b1;
      window     <= WINDOW_RST;
      lo         <= LO_RST;
      hi         <= HI_RST;
      min_f      <= MIN_RST;
      max_f      <= MAX_RST;
      freq       <= FREQ_RST;
      status_cnt <= '0;
    end else begin
      freq <= freq_next;
      if (win_done) status_cnt <= win_total;
      if (wr) begin
        case (apb_addr)
          ADDR_CTRL:   en <= apb_wdata[CTRL_EN_BIT];
          ADDR_WINDOW: window <= (apb_wdata[15:0] == 16'd0) ? 16'd1 : apb_wdata[15:0];
          ADDR_THRESH: begin
            lo <= apb_wdata[15:0];
            hi <= apb_wdata[THRESH_HI_LSB +: 16];
          end
          ADDR_LIMITS:
            if (apb_wdata[3:0] <= apb_wdata[LIMITS_MAX_LSB +: 4]) begin
              min_f <= apb_wdata[3:0];
              max_f <= apb_wdata[LIMITS_MAX_LSB +: 4];
            end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    apb_rdata = '0;
    if (apb_sel && !apb_we) begin
      case (apb_addr)
        ADDR_CTRL:   apb_rdata = {24'd0, man_freq, 2'd0, man, en};
        ADDR_WINDOW: apb_rdata = {16'd0, window};
        ADDR_THRESH: apb_rdata = {hi, lo};
        ADDR_LIMITS: apb_rdata = {20'd0, max_f, 4'd0, min_f};
        ADDR_STATUS: apb_rdata = {status_cnt, 12'd0, freq};
        default:     apb_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_avfs_controller.sv
// Self-checking bench for avfs_controller: per-window expected freq values are
// queued as stimulus is driven and checked by a scoreboard at each window end.
module tb_avfs_controller;

  logic        clk = 1'b0, rst_n = 1'b0, activity = 1'b0;
  logic        apb_sel = 1'b0, apb_we = 1'b0;
  logic [7:0]  apb_addr = '0;
  logic [31:0] apb_wdata = '0;
  logic [3:0]  freq_sel;
  logic [31:0] apb_rdata;

  avfs_controller dut (
    .clk(clk), .rst_n(rst_n), .activity(activity), .freq_sel(freq_sel),
    .apb_sel(apb_sel), .apb_we(apb_we), .apb_addr(apb_addr),
    .apb_wdata(apb_wdata), .apb_rdata(apb_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, win_no = 0;

  // reference state
  int         m_lo = 4, m_hi = 12, m_min = 0, m_max = 15;
  logic [3:0] m_f = 4'd8;
  logic [15:0] m_cnt = 16'd0;

  typedef struct { logic [3:0] freq; int idx; } exp_t;
  exp_t q[$];
  exp_t e;
  event win_end;

  always @(win_end) begin
    if (q.size() == 0) begin
      errors++; checks++;
      $display("FAIL sb_empty window=%0d", win_no);
    end else begin
      e = q.pop_front();
      checks++;
      if (freq_sel !== e.freq) begin
        errors++;
        $display("FAIL win_freq window=%0d got=%0d exp=%0d", e.idx, freq_sel, e.freq);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    apb_sel = 1'b1; apb_we = 1'b1; apb_addr = a; apb_wdata = d;
    tick();
    apb_sel = 1'b0; apb_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    apb_sel = 1'b1; apb_we = 1'b0; apb_addr = a;
    #1 d = apb_rdata;
    apb_sel = 1'b0;
  endtask

  function automatic logic [3:0] step(input logic [3:0] f, input int t);
    if (t >= m_hi && int'(f) < m_max) return f + 4'd1;
    if (t <= m_lo && int'(f) > m_min) return f - 4'd1;
    return f;
  endfunction

  // alt=1: activity on odd cycles; else activity on the first `ones` cycles
  task automatic drive_window(input int len, input int ones, input bit alt, input bit adapt);
    int t = 0;
    bit a;
    for (int i = 0; i < len; i++) begin
      if (i == len - 1 && len > 1) begin
        checks++;
        if (freq_sel !== m_f) begin
          errors++;
          $display("FAIL mid_window window=%0d got=%0d exp=%0d", win_no, freq_sel, m_f);
        end
      end
      a = alt ? i[0] : (i < ones);
      activity = a;
      t += int'(a);
      tick();
    end
    activity = 1'b0;
    if (adapt) begin
      m_f = step(m_f, t);
      m_cnt = t[15:0];
    end
    q.push_back('{freq: m_f, idx: win_no});
    ->win_end;
    win_no++;
    #0;
  endtask

  task automatic realign();
    wr(8'h08, {m_hi[15:0], m_lo[15:0]});
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    rd(8'h00, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL rst_ctrl got=%h exp=%h", d, 32'h1); end
    rd(8'h04, d); checks++;
    if (d !== 32'h10) begin errors++; $display("FAIL rst_window got=%h exp=%h", d, 32'h10); end
    rd(8'h08, d); checks++;
    if (d !== 32'h000C0004) begin errors++; $display("FAIL rst_thresh got=%h exp=%h", d, 32'h000C0004); end
    rd(8'h0C, d); checks++;
    if (d !== 32'h0F00) begin errors++; $display("FAIL rst_limits got=%h exp=%h", d, 32'h0F00); end
    rd(8'h10, d); checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL rst_status got=%h exp=%h", d, 32'h8); end
    checks++;
    if (freq_sel !== 4'd8) begin errors++; $display("FAIL rst_freq got=%0d exp=8", freq_sel); end
  endtask

  task automatic test_up();
    logic [31:0] d;
    drive_window(16, 16, 0, 1);
    rd(8'h10, d); checks++;
    if (d !== {16'd16, 16'd9}) begin errors++; $display("FAIL up_status got=%h exp=%h", d, {16'd16, 16'd9}); end
    for (int w = 0; w < 7; w++) drive_window(16, 16, 0, 1);
  endtask

  task automatic test_down();
    logic [31:0] d;
    for (int w = 0; w < 16; w++) drive_window(16, 0, 0, 1);
    wr(8'h0C, 32'h0503); checks++;
    if (freq_sel !== 4'd0) begin errors++; $display("FAIL lim_same_edge got=%0d exp=0", freq_sel); end
    tick(); checks++;
    if (freq_sel !== 4'd3) begin errors++; $display("FAIL lim_pull got=%0d exp=3", freq_sel); end
    m_min = 3; m_max = 5; m_f = 4'd3;
    wr(8'h0C, 32'h0209);
    rd(8'h0C, d); checks++;
    if (d !== 32'h0503) begin errors++; $display("FAIL lim_bad got=%h exp=%h", d, 32'h0503); end
    wr(8'h0C, 32'h0F00);
    m_min = 0; m_max = 15;
    realign();
  endtask

  task automatic test_hold();
    logic [31:0] d;
    drive_window(16, 0, 1, 1);
    drive_window(16, 0, 1, 1);
    wr(8'h00, 32'h0);
    drive_window(16, 16, 0, 0);
    drive_window(16, 16, 0, 0);
    rd(8'h10, d); checks++;
    if (d !== {16'd8, 12'd0, m_f}) begin errors++; $display("FAIL en0_status got=%h exp=%h", d, {16'd8, 12'd0, m_f}); end
    wr(8'h00, 32'h1);
    drive_window(16, 16, 0, 1);
  endtask

  task automatic test_thresh();
    drive_window(16, 12, 0, 1);
    drive_window(16, 11, 0, 1);
    drive_window(16, 4, 0, 1);
    drive_window(16, 5, 0, 1);
    m_lo = 8; m_hi = 8;
    realign();
    drive_window(16, 8, 0, 1);
    m_lo = 4; m_hi = 12;
    realign();
  endtask

  task automatic test_window();
    logic [31:0] d;
    wr(8'h04, 32'h0);
    rd(8'h04, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL win_zero got=%h exp=%h", d, 32'h1); end
    drive_window(1, 1, 0, 1);
    drive_window(1, 1, 0, 1);
    wr(8'h04, 32'h10); checks++;
    if (freq_sel !== m_f) begin errors++; $display("FAIL win_restart got=%0d exp=%0d", freq_sel, m_f); end
    drive_window(16, 16, 0, 1);
  endtask

  task automatic test_manual();
    logic [31:0] d;
`ifdef AVFS_MANUAL_EN
    wr(8'h00, 32'hFFFFFFFF);
    rd(8'h00, d); checks++;
    if (d !== 32'hF3) begin errors++; $display("FAIL man_ctrl got=%h exp=%h", d, 32'hF3); end
    checks++;
    if (freq_sel !== m_f) begin errors++; $display("FAIL man_early got=%0d exp=%0d", freq_sel, m_f); end
    tick(); checks++;
    if (freq_sel !== 4'd15) begin errors++; $display("FAIL man_freq got=%0d exp=15", freq_sel); end
    m_f = 4'd15;
    wr(8'h00, 32'h0);
    rd(8'h00, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL man_off got=%h exp=0", d); end
    drive_window(16, 0, 0, 0);
    wr(8'h00, 32'h1);
`else
    wr(8'h00, 32'hFFFFFFFF);
    rd(8'h00, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL noman_ctrl got=%h exp=%h", d, 32'h1); end
    realign();
`endif
    drive_window(16, 0, 0, 1);
  endtask

  task automatic test_misc();
    logic [31:0] d;
    rd(8'hFF, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rd_ff got=%h exp=0", d); end
    rd(8'h14, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rd_14 got=%h exp=0", d); end
    apb_sel = 1'b0; apb_we = 1'b0; apb_addr = 8'h04;
    #1 checks++;
    if (apb_rdata !== 32'h0) begin errors++; $display("FAIL rd_nosel got=%h exp=0", apb_rdata); end
    wr(8'h10, 32'hFFFFFFFF);
    rd(8'h10, d); checks++;
    if (d !== {m_cnt, 12'd0, m_f}) begin errors++; $display("FAIL status_ro got=%h exp=%h", d, {m_cnt, 12'd0, m_f}); end
    realign();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    activity = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    apb_sel = 1'b1; apb_we = 1'b1; apb_addr = 8'h04; apb_wdata = 32'h5;
    tick();
    apb_sel = 1'b0; apb_we = 1'b0; rst_n = 1'b1; activity = 1'b0;
    m_f = 4'd8; m_cnt = 16'd0;
    checks++;
    if (freq_sel !== 4'd8) begin errors++; $display("FAIL rmid_freq got=%0d exp=8", freq_sel); end
    rd(8'h04, d); checks++;
    if (d !== 32'h10) begin errors++; $display("FAIL rmid_window got=%h exp=%h", d, 32'h10); end
    rd(8'h10, d); checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL rmid_status got=%h exp=%h", d, 32'h8); end
    rd(8'h00, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL rmid_ctrl got=%h exp=%h", d, 32'h1); end
    drive_window(16, 16, 0, 1);
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_hold();
    test_thresh();
    test_window();
    test_manual();
    test_misc();
    test_reset_mid();
    #2;
    if (q.size() != 0) begin
      errors++; checks++;
      $display("FAIL sb_leftover n=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/avfs_controller.md
# avfs_controller

Adaptive voltage/frequency scaling controller. It measures the `activity` duty over a programmable window of clock cycles. At the end of each window it steps a 4-bit frequency selector up or down against programmable thresholds and limits. It sits between the core's activity monitor and the clock-generator/PLL select mux, and is configured through a simple single-cycle APB-style register port.

## Interface
- No parameters; register reset defaults are constants in the shared package.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `activity` input 1: 1 = core busy in this cycle.
- `freq_sel` output 4: frequency level, 0 = slowest, 15 = fastest; registered.
- `apb_sel` input 1: register access strobe.
- `apb_we` input 1: 1 = write, 0 = read.
- `apb_addr` input 8: byte address.
- `apb_wdata` input 32: write data.
- `apb_rdata` output 32: read data; combinational.

## Operation
Register map. Unlisted bits read 0; writes to them are ignored.
- 0x00 CTRL
  - bit0 EN, reset 1.
  - bit1 MAN, reset 0.
  - [7:4] MAN_FREQ, reset 0.
- 0x04 WINDOW [15:0]: window length in cycles, reset 16. A write of 0 stores 1.
- 0x08 THRESH
  - [15:0] LO, reset 4.
  - [31:16] HI, reset 12.
- 0x0C LIMITS
  - [3:0] MIN, reset 0.
  - [11:8] MAX, reset 15.
  - A write with new MIN > new MAX is discarded.
- 0x10 STATUS, read-only
  - [3:0] current freq_sel.
  - [31:16] activity count of the last completed window.
  - Writes ignored.
- Any other address: reads 0, writes ignored.

Register access:
- Write: when `apb_sel && apb_we` at a rising edge, the addressed register updates at that edge.
- Read: `apb_rdata` = addressed register when `apb_sel && !apb_we`, else 0.

Adaptation, when EN=1 and MAN=0:
- A window counter runs 0..WINDOW-1.
- An activity counter (16 bit) increments on each cycle with `activity`=1.
- On the last window cycle, total = count + current `activity`. Then:
  - total ≥ HI and freq_sel < MAX → freq_sel+1.
  - else total ≤ LO and freq_sel > MIN → freq_sel−1.
  - else hold.
- Up has priority over down if both conditions hold.
- total is latched into STATUS; both counters clear.
- freq_sel changes by at most one step per window.

Other modes and rules:
- EN=0: counters are held at 0 and freq_sel holds.
- MAN=1: freq_sel = clamp(MAN_FREQ, MIN, MAX) and counters are held at 0.
- A write to WINDOW or THRESH clears both counters, restarting the window.
- freq_sel is always clamped into [MIN,MAX]. A LIMITS write that excludes the current value pulls freq_sel to the nearest limit on the next edge.
- Reset values:
  - freq_sel = 4'h8.
  - Counters and STATUS count = 0.
  - Registers at the defaults listed above.

## Timing
- Register write visible on `apb_rdata` the cycle after the write edge.
- Adaptive step: freq_sel updates at the rising edge that ends the window, i.e. WINDOW cycles after the window started.
- Manual/clamp update: 1 cycle after the controlling write.
- Reset asserted mid-window or mid-access aborts everything; all state takes reset values at that edge and the write is lost.
- Reset has priority over a simultaneous APB write.

## Configuration
- `AVFS_MANUAL_EN` defined: the CTRL MAN and MAN_FREQ fields exist and operate as above.
- Undefined: MAN and MAN_FREQ are not implemented, read 0 and ignore writes; the controller is always adaptive.

## Structure
- Package `avfs_pkg`: register address constants, reset defaults (window 16, LO 4, HI 12, MIN 0, MAX 15, freq 8), field bit positions.
- Sub-module `avfs_activity_monitor`:
  - Contains the window counter and activity counter.
  - Inputs: clk, rst_n, en, restart, activity, window.
  - Outputs: a window-done pulse and the 16-bit total.
- The top module holds the register file, step/clamp logic and read mux.

## Test plan
- Reset, then read 0x00/0x04/0x08/0x0C → 0x1, 0x10, 0x000C0004, 0x0F00; freq_sel = 8.
- `activity`=1 constantly for 16 cycles → freq_sel 8→9 at the window end; STATUS[31:16] = 16. Continue → saturates at 15.
- `activity`=0 constantly → one step down per 16-cycle window until 0. Then write LIMITS MIN=3, MAX=5 → freq_sel becomes 3 next cycle.
- `activity` toggling 50% (count 8) → freq_sel holds. Write CTRL=0 → no change over several windows.
- Write 0xFFFFFFFF to 0x00 with `AVFS_MANUAL_EN` → CTRL reads 0xF3 and freq_sel = 15 next cycle. Write 0 → freq_sel holds, adaptation off.
- Read 0xFF → 0. Write to 0x10 is ignored. Pulse `rst_n`=0 mid-window → all reset values restored.
